// File: rtl/ws2812_string_ctrl.sv
// WS2812 string controller: pixel buffer plus periodic frame refresh
// in buffer, chase, fill or off mode, one pixel at a time to ws2812_tx.
module ws2812_string_ctrl #(
    parameter real F_CLK  = 48e6,
    parameter int  N_LEDS = 8,
    parameter real T_WAIT = 250e-3,
    localparam int AW     = $clog2(N_LEDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [23:0]   wdata,
    input  logic [1:0]    mode,
    input  logic [23:0]   chase_color,
    output logic          px_start,
    output logic [23:0]   px_data,
    input  logic          px_busy,
    output logic          frame_done,
    output logic [AW-1:0] chase_pos
);

    // Ceiling of the wait product, tolerant of floating-point noise.
    localparam real WAIT_R = T_WAIT * F_CLK;
    localparam int  WAIT_T = $rtoi(WAIT_R);
    localparam int  N_WAIT = (real'(WAIT_T) < WAIT_R - 1e-6) ? WAIT_T + 1 : WAIT_T;
    localparam int  CW     = $clog2(N_WAIT + 1);

    localparam logic [AW-1:0] LAST    = AW'(N_LEDS - 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(N_WAIT - 1);

    localparam logic [1:0] M_BUF   = 2'd0;
    localparam logic [1:0] M_CHASE = 2'd1;
    localparam logic [1:0] M_FILL  = 2'd2;

    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_START, S_BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [1:0]    frame_mode;
    logic [23:0]   mem [N_LEDS];
    logic [23:0]   src;
    logic          cnt_last, idx_last;
    logic          frame_go, frame_end, px_next;

    // Host write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (we && waddr <= LAST) mem[waddr] <= wdata;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_WAIT;
        else     state <= state_n;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_n   = state;
        cnt_last  = (cnt == CNT_TOP);
        idx_last  = (idx == LAST);
        frame_go  = 1'b0;
        frame_end = 1'b0;
        px_next   = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (cnt_last) begin
                    frame_go = 1'b1;
                    state_n  = S_LOAD;
                end
            end
            S_LOAD:  state_n = S_START;
            S_START: state_n = S_BUSY;
            S_BUSY: begin
                if (!px_busy) begin
                    frame_end = idx_last;
                    px_next   = !idx_last;
                    state_n   = idx_last ? S_WAIT : S_LOAD;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    // Pixel source for the current index under the latched frame mode.
    always_comb begin
        src = '0;
        unique case (frame_mode)
            M_BUF:   src = mem[idx];
            M_CHASE: src = (idx == chase_pos) ? chase_color : '0;
            M_FILL:  src = chase_color;
            default: src = '0;
        endcase
    end

    // Counters, frame latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            frame_mode <= M_BUF;
            chase_pos  <= LAST;
            px_start   <= 1'b0;
            px_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            px_start   <= (state == S_LOAD) || (state == S_START);
            if (state == S_WAIT) cnt <= cnt_last ? '0 : cnt + 1'b1;
            if (frame_go) begin
                frame_mode <= mode;
                idx        <= '0;
                if (mode == M_CHASE)
                    chase_pos <= (chase_pos == LAST) ? '0 : chase_pos + 1'b1;
            end
            if (px_next) idx <= idx + 1'b1;
            if (state == S_LOAD) px_data <= src;
        end
    end

endmodule

// File: tb/tb_ws2812_string_ctrl.sv
// Scoreboard bench for ws2812_string_ctrl with a ws2812_tx busy model
// and a frame-level reference model of the pixel stream.
module tb_ws2812_string_ctrl;

    localparam int N      = 5;
    localparam int N_WAIT = 48;
    localparam int LIM    = 3000;

    typedef struct {
        logic [23:0] px;
        logic [2:0]  cpos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [23:0] wdata;
    logic [1:0]  mode;
    logic [23:0] chase_color;
    logic        px_start;
    logic [23:0] px_data;
    logic        px_busy;
    logic        frame_done;
    logic [2:0]  chase_pos;

    ws2812_string_ctrl #(
        .F_CLK(48e6), .N_LEDS(N), .T_WAIT(1e-6)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .mode(mode), .chase_color(chase_color), .px_start(px_start),
        .px_data(px_data), .px_busy(px_busy), .frame_done(frame_done),
        .chase_pos(chase_pos)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t        exp_q[$];
    logic [23:0] mbuf [8];
    int          mcpos;
    int          pix_cnt   = 0;
    int          gap_ref   = 0;
    bit          gap_valid = 0;
    int          hold_len  = 10;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Serialiser model: busy for hold_len cycles after each px_start rise.
    int busy_cnt;
    logic start_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
            start_q  <= 1'b0;
        end else begin
            start_q <= px_start;
            if (px_start && !start_q) busy_cnt <= hold_len;
            else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
        end
    end
    assign px_busy = (busy_cnt != 0);

    // Monitor: pops the scoreboard on each new pixel request.
    logic prev_start = 1'b0;
    logic fd_prev    = 1'b0;
    int   width      = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            fd_prev    = 1'b0;
            width      = 0;
            pix_cnt    = 0;
        end else begin
            if (px_start && !prev_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 32'(px_data), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("px_data", 32'(px_data), 32'(e.px));
                    chk("chase_pos", 32'(chase_pos), 32'(e.cpos));
                end
                if (gap_valid) begin
                    chk("wait_gap", 32'(cyc - gap_ref), 32'(N_WAIT + 1));
                    gap_valid = 0;
                end
                pix_cnt++;
            end
            if (px_start) begin
                width++;
            end else if (prev_start) begin
                chk("px_start_width", 32'(width), 32'd2);
                width = 0;
            end
            if (frame_done) begin
                chk("pixels_per_frame", 32'(pix_cnt), 32'(N));
                chk("frame_done_pulse", 32'(fd_prev), 32'd0);
                pix_cnt   = 0;
                gap_ref   = cyc;
                gap_valid = 1;
            end
            prev_start = px_start;
            fd_prev    = frame_done;
        end
    end

    // Reference model: expected pixels of the next frame from the rules.
    task automatic push_frame();
        logic [23:0] p;
        if (mode == 2'd1) mcpos = (mcpos + 1) % N;
        for (int i = 0; i < N; i++) begin
            case (mode)
                2'd0:    p = mbuf[i];
                2'd1:    p = (i == mcpos) ? chase_color : 24'h0;
                2'd2:    p = chase_color;
                default: p = 24'h0;
            endcase
            exp_q.push_back('{px: p, cpos: 3'(mcpos)});
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
        if (int'(a) < N) mbuf[a] = d;
    endtask

    task automatic wait_fd();
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pix(input int k);
        for (int i = 0; i < LIM; i++) begin
            @(posedge clk); #1;
            if (pix_cnt >= k) return;
        end
        chk("pixel_timeout", 32'(pix_cnt), 32'(k));
    endtask

    task automatic wait_busy(input logic lvl);
        for (int i = 0; i < LIM; i++) begin
            @(posedge clk); #1;
            if (px_busy == lvl) return;
        end
        chk("busy_timeout", 32'(px_busy), 32'(lvl));
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        rst       = 1'b0;
        gap_ref   = cyc;
        gap_valid = 1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        mode = 2'd0; chase_color = '0;
        mcpos = N - 1;
        @(negedge clk);
        chk("rst_px_start", 32'(px_start), 32'd0);
        chk("rst_px_data", 32'(px_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_chase_pos", 32'(chase_pos), 32'(N - 1));
        wr(0, 24'h000011); wr(1, 24'h002200); wr(2, 24'h330000);
        wr(3, 24'h444444); wr(4, 24'h000055);
        release_rst();
        push_frame();
        wait_fd();

        mode = 2'd1; chase_color = 24'h005500;
        for (int f = 0; f < 6; f++) begin
            push_frame();
            wait_fd();
        end

        mode = 2'd2; chase_color = 24'h0A0B0C;
        push_frame();
        wait_pix(3);
        mode = 2'd3;
        wait_fd();
        push_frame();
        wait_fd();

        mode = 2'd0;
        wr(6, 24'h123456);
        push_frame();
        wait_pix(3);
        wait_busy(1'b1);
        wait_busy(1'b0);
        @(posedge clk); #1;
        we = 1'b1; waddr = 3'd3; wdata = 24'hFFFFFF;
        @(posedge clk); #1;
        we = 1'b0;
        mbuf[3] = 24'hFFFFFF;
        wait_fd();
        push_frame();
        wait_fd();

        push_frame();
        wait_pix(2);
        hold_len = 500;
        wait_pix(3);
        hold_len = 10;
        wait_fd();

        mode = 2'd1; chase_color = 24'h00FF00;
        push_frame();
        wait_fd();
        push_frame();
        wait_pix(3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_px_start", 32'(px_start), 32'd0);
        chk("midrst_chase_pos", 32'(chase_pos), 32'(N - 1));
        exp_q.delete();
        mcpos = N - 1;
        @(posedge clk);
        release_rst();
        push_frame();
        wait_fd();

        for (int f = 0; f < 8; f++) begin
            int nw;
            mode        = 2'($urandom_range(0, 3));
            chase_color = 24'($urandom);
            hold_len    = $urandom_range(1, 12);
            nw          = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                wr(3'($urandom_range(0, 7)), 24'($urandom));
            push_frame();
            wait_fd();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ws2812_string_ctrl.md
Name: ws2812_string_ctrl

Overview:
- Parametrised WS2812 string controller, successor to the fixed single-pattern string driver.
- Holds an N_LEDS-deep 24-bit pixel buffer that the host writes through a simple write port.
- Refreshes the whole string periodically in one of four run-time modes: buffer, chase, fill, off.
- Emits one pixel at a time over a start/busy handshake to an external ws2812_tx serialiser.

Parameters:
- F_CLK, 48e6, clock frequency in Hz.
- N_LEDS, 8, number of LEDs in the string, ≥2.
- T_WAIT, 250e-3, idle gap in seconds between frames, ≥50e-6; N_WAIT = ceil(T_WAIT*F_CLK).
- AW, $clog2(N_LEDS), pixel address width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  pixel buffer write enable.
- waddr  in  AW  write address, 0 = LED nearest dout.
- wdata  in  24  write data, GRB order as sent on the wire.
- mode  in  2  0 = buffer, 1 = chase, 2 = fill, 3 = off.
- chase_color  in  24  colour used by chase and fill modes.
- px_start  out  1  pixel transmit request to ws2812_tx.
- px_data  out  24  pixel value, valid while px_start = 1.
- px_busy  in  1  serialiser busy.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame completes.
- chase_pos  out  AW  currently lit LED index in chase mode.

Behaviour:
- Reset values:
  - state = WAIT, wait counter = 0, pixel index = 0.
  - px_start = 0, px_data = 0, frame_done = 0.
  - chase_pos = N_LEDS-1, so the first chase frame lights LED 0.
  - Buffer contents are not reset; they are undefined until written.
- Buffer writes:
  - Synchronous; when we = 1, buf[waddr] <= wdata at the clock edge.
  - Writes are accepted in every state.
  - waddr ≥ N_LEDS is ignored.
- FSM states and transitions:
  - WAIT: counter increments each cycle. When counter = N_WAIT-1: clear counter, latch mode into frame_mode, set index = 0, go to LOAD. If frame_mode latched as chase, chase_pos advances (N_LEDS-1 wraps to 0).
  - LOAD: register px_data from the selected source, set px_start = 1, go to START.
  - START: px_start stays 1 (two cycles total per pixel), go to BUSY.
  - BUSY: px_start = 0. Stay while px_busy = 1. On px_busy = 0: if index = N_LEDS-1, pulse frame_done for one cycle and go to WAIT; otherwise index+1 and go to LOAD.
- Pixel source, selected by frame_mode in LOAD:
  - buffer: buf[index].
  - chase: chase_color when index = chase_pos, else 0.
  - fill: chase_color.
  - off: 0.
- Mode timing:
  - mode is sampled only at frame start; changes mid-frame take effect at the next frame.
  - chase_pos holds its value in non-chase frames.
  - chase_color is sampled per pixel in LOAD.
- Read/write collision: a write in the same cycle as LOAD reads the same address → the old value is sent; the new value appears in the next frame.
- Serialiser contract: px_busy must rise no later than the cycle after px_start first rises. Throughput is one pixel per (3 + serialiser busy cycles).
- Minimum frame period = N_WAIT + N_LEDS*(3 + tx busy cycles). The WAIT gap also serves as the WS2812 latch/reset interval.
- Reset mid-frame:
  - px_start deasserts immediately (asynchronously).
  - State returns to WAIT, index and counter clear, chase_pos returns to N_LEDS-1.
  - The partially sent frame is not resumed.
- Width rules:
  - The counter is $clog2(N_WAIT+1) bits.
  - Index and chase_pos are AW bits and compare against N_LEDS-1, never against 2^AW-1, so non-power-of-2 N_LEDS wraps correctly.

Test Plan (bench: F_CLK=48e6, T_WAIT=1e-6 → N_WAIT=48, N_LEDS=5, tx model holds px_busy high 10 cycles after px_start):
- Buffer mode: write buf[0..4] = 0x000011, 0x002200, 0x330000, 0x444444, 0x000055, then mode = 0 → first frame emits those 5 px_data values in order, each with a 2-cycle px_start, then one frame_done pulse and a 48-cycle gap before the next px_start.
- Chase wrap: mode = 1, chase_color = 0x005500 → over 6 consecutive frames, chase_pos = 0, 1, 2, 3, 4, 0; in each frame only pixel[chase_pos] = 0x005500 and the others are 0.
- Fill/off and mid-frame mode change: mode = 2, chase_color = 0x0A0B0C → all 5 pixels = 0x0A0B0C. Switch mode = 3 during pixel 2 → the rest of that frame stays 0x0A0B0C; the next frame is all 0.
- Collision and ignored address: write buf[3] = 0xFFFFFF in the LOAD cycle of index 3 → that frame sends the old buf[3], the next frame sends 0xFFFFFF. A write to waddr = 6 changes nothing.
- Reset mid-operation: assert rst during BUSY of pixel 2 → px_start = 0 immediately; after release, 48 cycles of WAIT, then a full 5-pixel frame starting at index 0 with chase_pos restarting at 0.
- Slow serialiser: hold px_busy high 500 cycles for one pixel → FSM stays in BUSY, no extra px_start, and the frame completes correctly afterwards.
